// File: rtl/scratchpad_copy_pkg.sv
// Shared types, constants and the CRC-32 word update for scratchpad_copy_master.
package scratchpad_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // MSB-first, non-reflected CRC-32 over one 32-bit word, no final XOR.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 32; i++) begin
      if (c[31] ^ data[31 - i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                      c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/scratchpad_copy_master.sv
// Avalon-MM block copy master: one command, one outstanding read at a time.
// Optional CRC-32 of the copied words when SCRATCHPAD_COPY_CRC_EN is defined.
module scratchpad_copy_master
  import scratchpad_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
`ifdef SCRATCHPAD_COPY_CRC_EN
  ,
  output logic [31:0]       crc_out
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       data_q, data_d;
`ifdef SCRATCHPAD_COPY_CRC_EN
  logic [31:0]       crc_q, crc_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
`ifdef SCRATCHPAD_COPY_CRC_EN
      crc_q   <= CRC32_INIT;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
`ifdef SCRATCHPAD_COPY_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    data_d      = data_q;
`ifdef SCRATCHPAD_COPY_CRC_EN
    crc_d       = crc_q;
`endif
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    avm_address = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = {src_addr[ADDR_W-1:2], 2'b00};
          dst_d   = {dst_addr[ADDR_W-1:2], 2'b00};
          rem_d   = word_count;
`ifdef SCRATCHPAD_COPY_CRC_EN
          crc_d   = CRC32_INIT;
`endif
          state_d = (word_count == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = src_q;
        if (!avm_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        busy = 1'b1;
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
`ifdef SCRATCHPAD_COPY_CRC_EN
          crc_d   = crc32_word(crc_q, avm_readdata);
`endif
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        busy        = 1'b1;
        avm_write   = 1'b1;
        avm_address = dst_q;
        if (!avm_waitrequest) begin
          src_d   = src_q + ADDR_W'(WORD_BYTES);
          dst_d   = dst_q + ADDR_W'(WORD_BYTES);
          rem_d   = rem_q - LEN_W'(1);
          // Decide on the pre-decrement count so DONE follows the last write directly.
          state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign avm_writedata  = data_q;
  assign avm_byteenable = (avm_read || avm_write) ? BE_ALL : '0;
`ifdef SCRATCHPAD_COPY_CRC_EN
  assign crc_out        = crc_q;
`endif

endmodule

// File: tb/tb_scratchpad_copy_master.sv
// Self-checking bench for scratchpad_copy_master: behavioural memory/copy model,
// stalling slave with configurable read latency, per-cycle bus and status checks.
`timescale 1ns/1ps
module tb_scratchpad_copy_master;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 13;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
`ifdef SCRATCHPAD_COPY_CRC_EN
  logic [31:0]       crc_out;
`endif

  scratchpad_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
`ifdef SCRATCHPAD_COPY_CRC_EN
    ,
    .crc_out           (crc_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Slave memory (what the DUT sees) and reference memory (what it should become).
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] rd_log [$];

  int unsigned stall_cfg = 0;
  int unsigned lat_cfg   = 1;
  bit          noise_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Byte-at-a-time CRC-32, MSB first, init/no-final-xor handled by caller.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int j = 3; j >= 0; j--) begin
      b = w[j*8 +: 8];
      r = r ^ {b, 24'h0};
      for (int t = 0; t < 8; t++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    return r;
  endfunction

  // Slave responder and bus checker, evaluated once per cycle at the falling edge.
  initial begin : slave_and_check
    int unsigned stall_cnt;
    bit          rd_pend;
    int unsigned rd_cnt;
    logic [31:0] rd_data;
    bit          prev_stall, prev_rd, prev_wr, prev_rst;
    logic [31:0] prev_addr, prev_wd;
    stall_cnt = 0; rd_pend = 0; rd_cnt = 0; rd_data = '0;
    prev_stall = 0; prev_rd = 0; prev_wr = 0; prev_rst = 1; prev_addr = '0; prev_wd = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rd_data;
          rd_pend           = 1'b0;
        end
      end else if (noise_en && !busy && ($urandom_range(0, 3) == 0)) begin
        avm_readdatavalid = 1'b1;
      end

      avm_waitrequest = 1'($urandom_range(0, 1));
      if (avm_read || avm_write) begin
        if (stall_cnt < stall_cfg) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          if (!reset) begin
            if (avm_read) begin
              rd_pend = 1'b1;
              rd_cnt  = lat_cfg;
              rd_data = mem_rd(avm_address);
            end else begin
              mem[avm_address] = avm_writedata;
            end
          end
        end
      end
      if (reset) stall_cnt = 0;

      chk("rw_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (avm_read || avm_write) chk("byteenable", 32'(avm_byteenable), 32'hF);
      if (prev_stall && !prev_rst) begin
        chk("stall_read", 32'(avm_read), 32'(prev_rd));
        chk("stall_write", 32'(avm_write), 32'(prev_wr));
        chk("stall_addr", avm_address, prev_addr);
        if (prev_wr) chk("stall_wdata", avm_writedata, prev_wd);
      end
      if ((avm_read || avm_write) && !avm_waitrequest && !reset) begin
        if (avm_read) begin
          rd_log.push_back(avm_address);
          chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) chk("rd_addr", avm_address, exp_rd.pop_front());
        end else begin
          chk("wr_expected", 32'(exp_wa.size() > 0), 32'd1);
          if (exp_wa.size() > 0) begin
            chk("wr_addr", avm_address, exp_wa.pop_front());
            chk("wr_data", avm_writedata, exp_wd.pop_front());
          end
        end
      end
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      prev_rd    = avm_read;
      prev_wr    = avm_write;
      prev_addr  = avm_address;
      prev_wd    = avm_writedata;
      prev_rst   = reset;
    end
  end

  // Model one command: ascending word copy over the reference memory.
  task automatic plan(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                      output logic [31:0] crc);
    logic [31:0] sa, da, v;
    sa  = s & ~32'h3;
    da  = d & ~32'h3;
    crc = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      v = ref_rd(sa + 4 * i);
      exp_rd.push_back(sa + 4 * i);
      exp_wa.push_back(da + 4 * i);
      exp_wd.push_back(v);
      ref_mem[da + 4 * i] = v;
      crc = crc_ref(crc, v);
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                          input int unsigned st, input int unsigned lat, input bit glitch,
                          output int unsigned dcyc);
    logic [31:0] crc;
    int unsigned done_exp, k;
    bit          seen;
    plan(s, d, n, crc);
    stall_cfg = st;
    lat_cfg   = lat;
    done_exp  = (n == 0) ? 1 : n * (2 * st + 2 + lat) + 1;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; word_count = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; word_count = LEN_W'($urandom);
    k = 0; seen = 0; dcyc = 0;
    while (!seen && k < done_exp + 20) begin
      @(negedge clk);
      k++;
      if (glitch && done_exp >= 5 && k == 3) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom;
        word_count = LEN_W'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      chk("busy", 32'(busy), 32'(n > 0 && k < done_exp));
      chk("done", 32'(done), 32'(k == done_exp));
      if (done) begin
        seen = 1;
        dcyc = k;
`ifdef SCRATCHPAD_COPY_CRC_EN
        chk("crc_at_done", crc_out, crc);
`endif
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
`ifdef SCRATCHPAD_COPY_CRC_EN
    chk("crc_stable", crc_out, crc);
`endif
    chk("reads_left", exp_rd.size(), 32'd0);
    chk("writes_left", exp_wa.size(), 32'd0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int unsigned i = 0; i < n; i++)
      chk("mem_final", mem_rd((d & ~32'h3) + 4 * i), ref_rd((d & ~32'h3) + 4 * i));
  endtask

  initial begin : stimulus
    int unsigned dcyc;
    bit          found;
    logic [31:0] crc_dummy;
    logic [31:0] wrap_exp [4];
    logic [31:0] t1_data  [4];
    wrap_exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    t1_data  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
`ifdef SCRATCHPAD_COPY_CRC_EN
    chk("rst_crc", crc_out, 32'hFFFFFFFF);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic 4-word copy, zero wait, 1-cycle latency.
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 4 * i]     = t1_data[i];
      ref_mem[32'h100 + 4 * i] = t1_data[i];
    end
    rd_log.delete();
    run_copy(32'h0000_0100, 32'h0000_2000, 4, 0, 1, 0, dcyc);
    chk("t1_done_cycle", dcyc, 32'd13);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_log", rd_log[i], 32'h100 + 32'(4 * i));
      chk("t1_dst", mem_rd(32'h2000 + 4 * i), t1_data[i]);
    end

    // Same copy, 3 stall cycles on every request.
    for (int i = 0; i < 4; i++) mem[32'h2000 + 4 * i] = 32'h0;
    run_copy(32'h0000_0100, 32'h0000_2000, 4, 3, 1, 0, dcyc);
    chk("t2_done_cycle", dcyc, 32'd37);
    for (int i = 0; i < 4; i++) chk("t2_dst", mem_rd(32'h2000 + 4 * i), t1_data[i]);

    // Zero-length command.
    run_copy(32'h0000_0500, 32'h0000_0600, 0, 0, 1, 0, dcyc);
    chk("t3_done_cycle", dcyc, 32'd1);

    // Source wraps past the top of the address space; low bits ignored.
    rd_log.delete();
    run_copy(32'hFFFF_FFFA, 32'h0000_7000, 4, 0, 1, 0, dcyc);
    chk("t4_rd_count", rd_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) if (i < rd_log.size()) chk("t4_rd_addr", rd_log[i], wrap_exp[i]);

`ifdef SCRATCHPAD_COPY_CRC_EN
    mem[32'h4000] = 32'h0; ref_mem[32'h4000] = 32'h0;
    run_copy(32'h0000_4000, 32'h0000_5000, 1, 0, 1, 0, dcyc);
    chk("crc_zero_word", crc_out, 32'hC704DD7B);
`endif

    // Reset during the write of word 2 of 8, then a full restart.
    plan(32'h0000_8000, 32'h0000_9000, 8, crc_dummy);
    stall_cfg = 3; lat_cfg = 2;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h8000; dst_addr = 32'h9000; word_count = LEN_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (avm_write && exp_wa.size() == 7) found = 1;
    end
    chk("t5_reached_wr2", 32'(found), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_write_after_rst", 32'(avm_write), 32'd0);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    repeat (6) begin
      chk("t5_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    run_copy(32'h0000_8000, 32'h0000_9000, 8, 0, 1, 0, dcyc);
    chk("t5_done_cycle", dcyc, 32'd25);

    // Randomized commands: overlap, wrap, stalls, latency, stray valids, ignored starts.
    noise_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [31:0] s, d;
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom; d = $urandom;
      end else begin
        s = 32'h0001_0000 + $urandom_range(0, 63);
        d = 32'h0001_0000 + $urandom_range(0, 63);
      end
      run_copy(s, d, $urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(1, 3),
               1'($urandom_range(0, 1)), dcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scratchpad_copy_master.md
Name: scratchpad_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one slave region to another. Typical use: scratchpad to shared memory, or the reverse.
- It is the initiator side of the interface the processor scratchpads expose. The fingerprint monitor or the processor control logic uses it to stage task data in and out of a core's scratchpad.
- One transfer at a time, one outstanding read at a time.
- Control is a simple start/len/addr command port with busy/done status.

Parameters:
- ADDR_W, 32, byte-address width of the master port.
- LEN_W, 13, width of the word count; maximum 4096 words per command.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; bits [1:0] forced to 0.
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] forced to 0.
- word_count  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- avm_address  out  ADDR_W  master byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  always 4'hF while read or write is asserted.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.

Behaviour:
- Reset (synchronous): state=IDLE. busy, done, avm_read and avm_write are 0. avm_address and avm_writedata are 0. Internal counters are 0. A reset mid-transfer abandons it at that edge, with no done pulse; a read response arriving after reset is ignored.
- Command latch: on start in IDLE, latch src, dst and count with low address bits cleared.
  - count==0: go to DONE directly; done pulses on the next cycle and no bus cycle is issued.
  - start while busy is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- RD_REQ: avm_read=1 and avm_address=src_ptr, held stable while avm_waitrequest=1. On waitrequest=0, go to RD_WAIT with avm_read=0.
- RD_WAIT: on avm_readdatavalid, capture readdata into avm_writedata and go to WR_REQ. Read latency is unbounded; a fixed latency of 1 (scratchpad) is handled identically.
- WR_REQ: avm_write=1, avm_address=dst_ptr, data held while waitrequest=1. On acceptance:
  - src_ptr+=4, dst_ptr+=4, remaining-=1.
  - If remaining reaches 0, go to DONE; else go to RD_REQ.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Throughput: minimum 3 cycles per word with zero waitrequest and 1-cycle read latency.
- Address arithmetic: modulo 2^ADDR_W. Wrap-around past the top of the space is legal and is not flagged.
- Overlap: src/dst overlap is permitted. Copy order is ascending, so copying to a higher overlapping address replicates data.
- Never assert avm_read and avm_write in the same cycle.
- readdatavalid outside RD_WAIT is ignored.

Optional Feature:
- Macro: SCRATCHPAD_COPY_CRC_EN.
- When defined:
  - Add output crc_out[31:0].
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR) is folded over each word in the cycle it is captured in RD_WAIT.
  - crc_out is re-initialised on accepted start and is valid and stable from the done pulse until the next start.
  - Reset value is 0xFFFFFFFF.
- When undefined: no crc_out port and no CRC logic.

Decomposition:
- Package scratchpad_copy_pkg holds:
  - the state enum typedef;
  - the constants WORD_BYTES=4, BE_ALL=4'hF, CRC32_POLY, CRC32_INIT;
  - a function crc32_word(crc, data) for a 32-bit-parallel update.
- No sub-module is needed. If the CRC is included, it lives as the package function, not a separate module.

Test Plan:
- Copy 4 words, src=0x0000_0100, dst=0x0000_2000, zero-wait slave with 1-cycle latency -> reads at 0x100..0x10C, writes at 0x2000..0x200C with matching data. done pulses once, 12 cycles after busy rises.
- Same copy with waitrequest asserted 3 cycles on every read and write -> address, data and control stay stable while stalled; final memory contents are identical.
- word_count=0 -> no avm_read/avm_write ever asserted; done pulses one cycle after start.
- src=0xFFFF_FFF8, count=4 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset asserted in WR_REQ of word 2 of 8 -> next cycle avm_write=0 and busy=0, no done pulse. A new start then copies all 8 words correctly.
- With SCRATCHPAD_COPY_CRC_EN, copy one word 0x00000000 -> crc_out=0xC704DD7B at done.
